twiddle_sequencer: RTL
======================

// Module: twiddle_sequencer
// PURPOSE
//  Drives the twiddle_t and sw inputs of a single-path FFT stage rotator.
//  The sample stream is word-serial: re_n, then im_n, gapless within a frame.
//  Tracks frame position and fetches W_N^k from an elaboration-time ROM.
//  Asserts sw on imaginary-word cycles, the point where the rotator closes each complex product.
//  Sits one cycle ahead of the rotator's din tap, beside the stage's delay-commutator.
// PARAMETERS
//  N_POINTS  64  FFT length in complex samples; power of 2, >=4
//  STAGE     0   stage index, 0..log2(N_POINTS)-2; sets group size G = N_POINTS>>STAGE
//  (TWIDDLE_WIDTH from fft_pkg; twiddle_t = {cos, sin}, signed Q1.(TWIDDLE_WIDTH-1))
// PORTS
//  clk        in   1              clock
//  rst_n      in   1              synchronous reset, active low
//  in_valid   in   1              word present, one cycle before it reaches rotator din
//  in_sop     in   1              first word (re_0) of a frame; qualified by in_valid
//  sw         out  1              1 on im words: rotator real result; 0 otherwise
//  twiddle    out  twiddle_t      W_N^k for the current complex sample
//  out_valid  out  1              in_valid delayed by 1
//  frame_done out  1              1-cycle pulse, aligned with the im_(N-1) word
//  err        out  1              sticky gap/overrun flag; cleared by next in_sop
// BEHAVIOUR
//  - Reset: state IDLE, word counter 0, sw=0, out_valid=0, frame_done=0, err=0, twiddle={max_pos,0}.
//  - Latency: every output is registered, 1 cycle after its in_* word.
//  - FSM IDLE: waits for in_valid&in_sop, then RUN with counter w=0.
//    Words outside a frame are ignored; out_valid still follows in_valid.
//  - FSM RUN: w increments on each in_valid cycle, 0..2*N_POINTS-1.
//    phase = w[0], n = w>>1.
//  - RUN, w == 2N-1: pulse frame_done.
//    With in_sop on the next cycle: restart at w=0, no idle cycle.
//    Otherwise: go to IDLE.
//  - Gap (in_valid=0 while in RUN): set err, go to IDLE.
//  - in_sop while w != 0: set err, restart at w=0. The new frame wins.
//  - sw = phase of the aligned word, so sw toggles 0,1,0,1,... starting with 0 on re_0.
//  - Twiddle index: pos = n mod G; k = (pos >= G/2) ? (pos - G/2) << STAGE : 0.
//  - Twiddle update: loads when the im_n word emerges (sw=1).
//    Holds through the following re_(n+1) cycle.
//    This keeps the rotator's 2-cycle product on a single W.
//  - ROM: N_POINTS/2 entries built at elaboration with $cos/$sin.
//    cos_q = round(cos(2*pi*k/N) * 2^(TW-1)), clipped to 2^(TW-1)-1.
//    sin_q = round(-sin(2*pi*k/N) * 2^(TW-1)), clipped to [-2^(TW-1), 2^(TW-1)-1].
//    Forward transform, W = exp(-j*2*pi*k/N).
//  - k=0 gives {2^(TW-1)-1, 0}: unity minus 1 LSB, accepted.
//  - rst_n low mid-frame: same-cycle-next-edge return to reset values; the partial frame is dropped.
// CONFIGURATION
//  TWIDDLE_INVERSE_EN defined:
//    - Adds input port inv (1 bit), sampled only on in_sop.
//    - inv=1 negates sin_q for the whole frame (conjugate twiddle, IFFT).
//    - A negated value of -2^(TW-1) clips to 2^(TW-1)-1.
//  TWIDDLE_INVERSE_EN undefined:
//    - No inv port; forward twiddles only.
// TESTING
//  (N_POINTS=16, STAGE=0, TW=16 unless stated)
//  1 Reset then one gapless 32-word frame:
//    sw = 0,1,0,1...; frame_done exactly once, with word 31; err=0.
//  2 Twiddle checks, frame of scenario 1:
//    n=3:  {32767,0}
//    n=9:  {30274,-12540}
//    n=12: {0,-32768}
//    n=15: {-30274,-12540}
//    Each value held across im_n and re_(n+1).
//  3 STAGE=1:
//    n=5: k=2 -> {23170,-23170}
//    n=1: k=0 -> {32767,0}
//  4 Back-to-back frames:
//    in_sop at w=31+1 -> counter restarts, no bubble, two frame_done pulses 32 cycles apart.
//  5 in_valid low at w=10:
//    err=1, FSM IDLE, twiddle frozen.
//    Next in_sop clears err; frame proceeds normally.
//  6 rst_n low at w=20:
//    all outputs at reset values next cycle.
//    With TWIDDLE_INVERSE_EN, inv=1: n=9 -> {30274,12540}.

Source files
------------

// File: rtl/twiddle_sequencer.sv
// twiddle_sequencer: frame-position tracker and elaboration-time twiddle ROM for a word-serial FFT stage rotator.
// Optional feature macro TWIDDLE_INVERSE_EN adds the inv port (conjugate twiddles for IFFT frames).
package fft_pkg;
    localparam int TWIDDLE_WIDTH = 16;
    typedef logic [2*TWIDDLE_WIDTH-1:0] twiddle_t;
endpackage

module twiddle_sequencer #(
    parameter int N_POINTS = 64,
    parameter int STAGE    = 0
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 in_valid,
    input  logic                                 in_sop,
`ifdef TWIDDLE_INVERSE_EN
    input  logic                                 inv,
`endif
    output logic                                 sw,
    output logic [2*fft_pkg::TWIDDLE_WIDTH-1:0]  twiddle,
    output logic                                 out_valid,
    output logic                                 frame_done,
    output logic                                 err
);
    localparam int TW   = fft_pkg::TWIDDLE_WIDTH;
    localparam int CW   = $clog2(2 * N_POINTS);
    localparam int NW   = $clog2(N_POINTS);
    localparam int KW   = NW - 1;
    localparam int G    = N_POINTS >> STAGE;
    localparam int MAXI = (2 ** (TW - 1)) - 1;
    localparam int MINI = -(2 ** (TW - 1));
    localparam real PI    = 3.14159265358979323846;
    localparam real SCALE = 2.0 ** (TW - 1);
    localparam logic [CW-1:0] LAST_W  = CW'(2 * N_POINTS - 1);
    localparam logic [NW-1:0] HALF_G  = NW'(G / 2);
    localparam logic [NW-1:0] MASK_G  = NW'(G - 1);
    localparam logic [TW-1:0] MAX_POS = {1'b0, {(TW-1){1'b1}}};
    localparam logic [TW-1:0] MIN_NEG = {1'b1, {(TW-1){1'b0}}};
    localparam logic [2*TW-1:0] TW_UNITY = {MAX_POS, {TW{1'b0}}};

    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

    state_t            r_state, w_state_nxt;
    logic [CW-1:0]     r_cnt, w_cnt_nxt;
    logic              r_sw, r_ov, r_fd, r_err;
    logic [2*TW-1:0]   r_tw, w_tw_nxt;
    logic              w_in_frame, w_err_set, w_err_nxt, w_sw_nxt, w_fd_nxt;
    logic [CW-1:0]     w_idx;
    logic [NW-1:0]     w_n, w_pos;
    logic [KW-1:0]     w_koff, w_k;
    logic [2*TW-1:0]   w_rom_tw, w_tw_sel;
    logic [2*TW-1:0]   w_rom [N_POINTS/2];

    // W_N^k = {round(cos), round(-sin)} in Q1.(TW-1); only cos(0) can exceed the positive range
    for (genvar gk = 0; gk < N_POINTS / 2; gk++) begin : g_rom
        localparam real ANG   = 2.0 * PI * gk / N_POINTS;
        localparam int  COS_R = int'($cos(ANG) * SCALE);
        localparam int  SIN_R = int'(-$sin(ANG) * SCALE);
        localparam int  COS_Q = (COS_R > MAXI) ? MAXI : COS_R;
        localparam int  SIN_Q = (SIN_R > MAXI) ? MAXI : ((SIN_R < MINI) ? MINI : SIN_R);
        assign w_rom[gk] = {TW'(COS_Q), TW'(SIN_Q)};
    end

    assign w_n      = w_idx[CW-1:1];
    assign w_pos    = w_n & MASK_G;
    assign w_koff   = KW'(w_pos - HALF_G) << STAGE;
    assign w_k      = (w_pos >= HALF_G) ? w_koff : '0;
    assign w_rom_tw = w_rom[w_k];

`ifdef TWIDDLE_INVERSE_EN
    logic r_inv;

    function automatic logic [TW-1:0] conj_sin(input logic [TW-1:0] s);
        if (s == MIN_NEG) begin
            return MAX_POS;
        end else begin
            return -s;
        end
    endfunction

    assign w_tw_sel = r_inv ? {w_rom_tw[2*TW-1:TW], conj_sin(w_rom_tw[TW-1:0])} : w_rom_tw;

    // Frame direction latched on each accepted start of frame
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_inv <= 1'b0;
        end else if (in_valid && in_sop) begin
            r_inv <= inv;
        end else begin
            r_inv <= r_inv;
        end
    end
`else
    assign w_tw_sel = w_rom_tw;
`endif

    // Frame tracking: word index of the current input, error detection and next state
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_in_frame  = 1'b0;
        w_idx       = '0;
        w_err_set   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (in_valid && in_sop) begin
                    w_in_frame = 1'b1;
                end else begin
                    w_in_frame = 1'b0;
                end
            end
            S_RUN: begin
                if (!in_valid) begin
                    w_err_set   = 1'b1;
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else if (in_sop) begin
                    w_err_set  = 1'b1;
                    w_in_frame = 1'b1;
                end else begin
                    w_in_frame = 1'b1;
                    w_idx      = r_cnt;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
        // Last word returns to IDLE; an immediate in_sop is then accepted with no bubble
        if (w_in_frame) begin
            if (w_idx == LAST_W) begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end else begin
                w_state_nxt = S_RUN;
                w_cnt_nxt   = w_idx + CW'(1);
            end
        end else begin
            w_cnt_nxt = w_cnt_nxt;
        end
        if (w_err_set) begin
            w_err_nxt = 1'b1;
        end else if (in_valid && in_sop) begin
            w_err_nxt = 1'b0;
        end else begin
            w_err_nxt = r_err;
        end
        w_sw_nxt = w_in_frame & w_idx[0];
        w_fd_nxt = w_in_frame && (w_idx == LAST_W);
        if (w_sw_nxt) begin
            w_tw_nxt = w_tw_sel;
        end else begin
            w_tw_nxt = r_tw;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_sw    <= 1'b0;
            r_ov    <= 1'b0;
            r_fd    <= 1'b0;
            r_err   <= 1'b0;
            r_tw    <= TW_UNITY;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_sw    <= w_sw_nxt;
            r_ov    <= in_valid;
            r_fd    <= w_fd_nxt;
            r_err   <= w_err_nxt;
            r_tw    <= w_tw_nxt;
        end
    end

    assign sw         = r_sw;
    assign twiddle    = r_tw;
    assign out_valid  = r_ov;
    assign frame_done = r_fd;
    assign err        = r_err;

endmodule
